// File: rtl/debouncer_core.sv
// Switch/button debouncer: synchronizes `noisy`, then moves `clean` only after STABLE_CYCLES agreeing samples.
// Latency: SYNC_STAGES+STABLE_CYCLES edges for either edge direction; no backpressure (free-running level path).
module debouncer_core #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      clean  <= 1'b0;
    end else begin
      sync_q[0] <= noisy;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      // CNT_MAX is terminal: it always resolves to an update, so cnt never wraps
      if (sync == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        clean <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_debouncer_core.sv
// Bench for debouncer_core (STABLE_CYCLES=4, SYNC_STAGES=2): window-based reference model plus directed literal checks.
module tb_debouncer_core;

  localparam int S    = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  logic noisy;
  logic clean;

  int tests = 0;
  int fails = 0;

  debouncer_core #(.STABLE_CYCLES(S), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .noisy (noisy),
    .clean (clean)
  );

  always #10 clk = ~clk;

  // Reference model: `clean` moves to v once the last S pre-edge synchronized
  // samples (all taken since the last reset) equal v and differ from `clean`.
  int edge_n   = 0;
  int last_rst = -100;
  bit noisy_at [0:1023];
  bit m_clean  = 1'b0;
  bit m_valid  = 1'b0;

  // Synchronized value after edge n: the noisy sample from SYNC-1 edges earlier,
  // or 0 if that sample was wiped by a reset.
  function automatic bit sync_after(int n);
    int idx;
    idx = n - SYNC + 1;
    if (idx <= last_rst || idx < 0 || idx > 1023) return 1'b0;
    return noisy_at[idx];
  endfunction

  always @(posedge clk) begin
    bit ok;
    bit v;
    edge_n++;
    if (edge_n <= 1023) noisy_at[edge_n] = noisy;
    if (reset) begin
      last_rst = edge_n;
      m_clean  = 1'b0;
      m_valid  = 1'b1;
    end else begin
      ok = (edge_n - last_rst >= S);
      v  = sync_after(edge_n - 1);
      for (int k = 0; k < S; k++) begin
        if (sync_after(edge_n - 1 - k) != v) ok = 1'b0;
      end
      if (ok && v != m_clean) m_clean = v;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (clean !== m_clean) begin
        fails++;
        $display("FAIL model_cmp edge %0d: clean=%b expected %b", edge_n, clean, m_clean);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] pat;
    reset = 1'b1;
    noisy = 1'b1;
    @(negedge clk);

    // Reset holds clean and cnt at 0 even with noisy high
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_clean", 32'(clean), 32'd0);
      chk("reset_cnt", 32'(dut.cnt), 32'd0);
    end

    // Clean rise: exactly on the 6th edge after noisy goes high
    reset = 1'b0;
    noisy = 1'b0;
    repeat (3) tick();
    noisy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("rise_e%0d", i), 32'(clean), (i == 6) ? 32'd1 : 32'd0);
    end

    // Return to 0 so the glitch test starts from clean=0
    noisy = 1'b0;
    repeat (8) tick();
    chk("settle_low", 32'(clean), 32'd0);

    // Glitch reject: pulses of 1, 2, 3 cycles
    for (int w = 1; w <= 3; w++) begin
      noisy = 1'b1;
      repeat (w) tick();
      noisy = 1'b0;
      repeat (5) tick();
      chk($sformatf("glitch%0d_clean", w), 32'(clean), 32'd0);
      chk($sformatf("glitch%0d_cnt", w), 32'(dut.cnt), 32'd0);
    end

    // Bounce then settle high
    for (int i = 0; i < 10; i++) begin
      noisy = (i % 2 == 0);
      tick();
    end
    noisy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("bounce_rise_e%0d", i), 32'(clean), (i == 6) ? 32'd1 : 32'd0);
    end

    // Bounce then settle low: same latency
    for (int i = 0; i < 10; i++) begin
      noisy = (i % 2 == 1);
      tick();
    end
    noisy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("bounce_fall_e%0d", i), 32'(clean), (i == 6) ? 32'd0 : 32'd1);
    end

    // Mid-count reset
    noisy = 1'b1;
    repeat (4) tick();
    chk("midcount_cnt", 32'(dut.cnt), 32'd2);
    reset = 1'b1;
    tick();
    chk("midrst_clean", 32'(clean), 32'd0);
    chk("midrst_cnt", 32'(dut.cnt), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("post_rst_e%0d", i), 32'(clean), (i == 6) ? 32'd1 : 32'd0);
    end

    // Mixed pattern, checked only by the model
    pat = 64'hF0F3_0FFF_00C3_FF00;
    for (int i = 63; i >= 0; i--) begin
      noisy = pat[i];
      tick();
    end
    noisy = 1'b0;
    repeat (8) tick();
    chk("final_low", 32'(clean), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
